// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream types: FIFO status flags and TCDM port widths.
package hwpe_stream_package;

  typedef struct packed {
    logic       empty;
    logic       full;
    logic [7:0] push_pointer;
    logic [7:0] pop_pointer;
  } flags_fifo_t;

  localparam int unsigned TCDM_BE_WIDTH   = 4;
  localparam int unsigned TCDM_ADDR_WIDTH = 32;
  localparam int unsigned TCDM_DATA_WIDTH = 32;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response port bundle between streamers, FIFOs and the interconnect.
interface hwpe_stream_intf_tcdm;
  import hwpe_stream_package::*;

  logic                       req;
  logic                       gnt;
  logic [TCDM_ADDR_WIDTH-1:0] add;
  logic                       wen;
  logic [TCDM_BE_WIDTH-1:0]   be;
  logic [TCDM_DATA_WIDTH-1:0] data;
  logic [TCDM_DATA_WIDTH-1:0] r_data;
  logic                       r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/hwpe_stream_fifo_sidech.sv
// Request FIFO carrying a payload plus a side channel; no fall-through, head held until popped.
module hwpe_stream_fifo_sidech
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH   = 68,
  parameter int unsigned SIDECH_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter bit          LATCH_FIFO   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  output flags_fifo_t             flags_o,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic [SIDECH_WIDTH-1:0] push_sidech,
  output logic                    pop_valid,
  input  logic                    pop_ready,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic [SIDECH_WIDTH-1:0] pop_sidech
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_WIDTH + SIDECH_WIDTH;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          push, pop, fresh;

  assign push_ready = (cnt_q != (AW+1)'(FIFO_DEPTH));
  assign push       = push_valid & push_ready;
  // an entry still being written into latch storage is not yet visible at the head
  assign pop_valid  = (cnt_q > (AW+1)'(fresh));
  assign pop        = pop_valid & pop_ready;
  assign {pop_data, pop_sidech} = mem[rptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  if (LATCH_FIFO) begin : gen_latch
    logic [EW-1:0] wdata_q;
    logic [AW-1:0] waddr_q;
    logic          we_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) we_q <= 1'b0;
      else       we_q <= push & ~clear_i;
    end

    always_ff @(posedge clk_i) begin
      if (push) begin
        wdata_q <= {push_data, push_sidech};
        waddr_q <= wptr_q;
      end
    end

    // latches open during the low clock phase after the write was staged
    always_latch begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (we_q && !clk_i && (waddr_q == AW'(i))) mem[i] <= wdata_q;
      end
    end

    assign fresh = we_q;
  end else begin : gen_flop
    always_ff @(posedge clk_i) begin
      if (push) mem[wptr_q] <= {push_data, push_sidech};
    end

    assign fresh = 1'b0;
  end

  assign flags_o.empty        = (cnt_q == '0);
  assign flags_o.full         = ~push_ready;
  assign flags_o.push_pointer = 8'(wptr_q);
  assign flags_o.pop_pointer  = 8'(rptr_q);

endmodule

// File: rtl/hwpe_stream_tcdm_fifo_store_sidech.sv
// Store-side TCDM decoupling FIFO: posts streamer writes, issues them to the interconnect and
// returns each write's side channel when the interconnect acknowledges it.
module hwpe_stream_tcdm_fifo_store_sidech
  import hwpe_stream_package::*;
#(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter bit          LATCH_FIFO      = 1'b0,
  parameter int unsigned SIDECH_WIDTH    = 1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  output flags_fifo_t             flags_o,
  hwpe_stream_intf_tcdm.slave     tcdm_slave,
  hwpe_stream_intf_tcdm.master    tcdm_master,
  input  logic [SIDECH_WIDTH-1:0] sidech_i,
  output logic [SIDECH_WIDTH-1:0] sidech_o,
  output logic                    sidech_valid_o
);

  localparam int unsigned REQ_W = TCDM_BE_WIDTH + TCDM_ADDR_WIDTH + TCDM_DATA_WIDTH;
  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned CW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  function automatic logic [CW-1:0] cq_inc(input logic [CW-1:0] p);
    return (p == CW'(MAX_OUTSTANDING - 1)) ? '0 : p + CW'(1);
  endfunction

  flags_fifo_t             req_flags;
  logic                    req_push, head_valid, can_issue, issue, ack;
  logic [REQ_W-1:0]        head_data;
  logic [SIDECH_WIDTH-1:0] head_sidech;
  logic                    vld_p1;
  logic [OW-1:0]           out_cnt_q;
  logic [SIDECH_WIDTH-1:0] cq_mem [MAX_OUTSTANDING];
  logic [CW-1:0]           cq_wptr_q, cq_rptr_q;
  logic [SIDECH_WIDTH-1:0] sidech_last_q;
  logic                    unused_rdata;

  assign req_push = tcdm_slave.req & tcdm_slave.gnt;

  hwpe_stream_fifo_sidech #(
    .DATA_WIDTH   ( REQ_W        ),
    .SIDECH_WIDTH ( SIDECH_WIDTH ),
    .FIFO_DEPTH   ( FIFO_DEPTH   ),
    .LATCH_FIFO   ( LATCH_FIFO   )
  ) i_req_fifo (
    .clk_i       ( clk_i                                             ),
    .rst_i       ( rst_i                                             ),
    .clear_i     ( clear_i                                           ),
    .flags_o     ( req_flags                                         ),
    .push_valid  ( tcdm_slave.req                                    ),
    .push_ready  ( tcdm_slave.gnt                                    ),
    .push_data   ( {tcdm_slave.be, tcdm_slave.add, tcdm_slave.data} ),
    .push_sidech ( sidech_i                                          ),
    .pop_valid   ( head_valid                                        ),
    .pop_ready   ( tcdm_master.gnt & can_issue                       ),
    .pop_data    ( head_data                                         ),
    .pop_sidech  ( head_sidech                                       )
  );

  // gate issue on the registered outstanding count only
  assign can_issue       = (out_cnt_q < OW'(MAX_OUTSTANDING));
  assign tcdm_master.req = head_valid & can_issue;
  assign {tcdm_master.be, tcdm_master.add, tcdm_master.data} = head_data;
  assign tcdm_master.wen = 1'b0;
  assign issue           = tcdm_master.req & tcdm_master.gnt;
  assign ack             = tcdm_master.r_valid & (out_cnt_q != '0);
  assign unused_rdata    = ^tcdm_master.r_data;

  assign tcdm_slave.r_valid = vld_p1;
  assign tcdm_slave.r_data  = '0;
  assign sidech_valid_o     = ack;
  assign sidech_o           = ack ? cq_mem[cq_rptr_q] : sidech_last_q;

  always_comb begin
    flags_o       = req_flags;
    flags_o.empty = req_flags.empty & (out_cnt_q == '0);
  end

  // stage p1: posted-write response and completion bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1        <= 1'b0;
      out_cnt_q     <= '0;
      cq_wptr_q     <= '0;
      cq_rptr_q     <= '0;
      sidech_last_q <= '0;
    end else if (clear_i) begin
      vld_p1    <= 1'b0;
      out_cnt_q <= '0;
      cq_wptr_q <= '0;
      cq_rptr_q <= '0;
    end else begin
      vld_p1 <= req_push;
      if (issue) cq_wptr_q <= cq_inc(cq_wptr_q);
      if (ack) begin
        cq_rptr_q     <= cq_inc(cq_rptr_q);
        sidech_last_q <= cq_mem[cq_rptr_q];
      end
      case ({issue, ack})
        2'b10:   out_cnt_q <= out_cnt_q + OW'(1);
        2'b01:   out_cnt_q <= out_cnt_q - OW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) cq_mem[cq_wptr_q] <= head_sidech;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && tcdm_slave.req) begin
      assert (!tcdm_slave.wen) else $error("read request on store-side TCDM FIFO");
    end
    if (!rst_i && tcdm_master.r_valid) begin
      assert (out_cnt_q != '0) else $warning("write ack with nothing outstanding, dropped");
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_store_sidech.sv
// Directed bench for the store-side TCDM sidech FIFO.
module tb_hwpe_stream_tcdm_fifo_store_sidech;
  import hwpe_stream_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  flags_fifo_t flags;
  logic [3:0]  sidech_in, sidech_out;
  logic        sidech_vld;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          grants;

  hwpe_stream_intf_tcdm slv ();
  hwpe_stream_intf_tcdm mst ();

  hwpe_stream_tcdm_fifo_store_sidech #(
    .FIFO_DEPTH      ( 8    ),
    .LATCH_FIFO      ( 1'b0 ),
    .SIDECH_WIDTH    ( 4    ),
    .MAX_OUTSTANDING ( 4    )
  ) dut (
    .clk_i          ( clk        ),
    .rst_i          ( rst        ),
    .clear_i        ( clear      ),
    .flags_o        ( flags      ),
    .tcdm_slave     ( slv        ),
    .tcdm_master    ( mst        ),
    .sidech_i       ( sidech_in  ),
    .sidech_o       ( sidech_out ),
    .sidech_valid_o ( sidech_vld )
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // back-to-back writes while the slave side is not full
  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      slv.req   = 1'b1;
      slv.add   = 32'h200 + 32'(4 * i);
      slv.data  = base + 32'(i);
      slv.be    = 4'hF;
      sidech_in = 4'(i);
      cyc();
    end
    slv.req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; sidech_in = '0;
    slv.req = 1'b0; slv.add = '0; slv.wen = 1'b0; slv.be = '0; slv.data = '0;
    mst.gnt = 1'b0; mst.r_valid = 1'b0; mst.r_data = '0;
    #2;
    chk("rst_mreq", mst.req, 0);
    chk("rst_srvalid", slv.r_valid, 0);
    chk("rst_sidech_vld", sidech_vld, 0);
    chk("rst_sidech", sidech_out, 0);
    chk("rst_empty", flags.empty, 1);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_sgnt", slv.gnt, 1);

    // single write through to completion
    slv.req = 1'b1; slv.add = 32'h100; slv.data = 32'hCAFE; slv.be = 4'hF; sidech_in = 4'd1;
    #1;
    chk("t1_sgnt", slv.gnt, 1);
    chk("t1_nofall", mst.req, 0);
    cyc();
    slv.req = 1'b0; mst.gnt = 1'b1;
    #1;
    chk("t1_srvalid", slv.r_valid, 1);
    chk("t1_srdata", slv.r_data, 0);
    chk("t1_mreq", mst.req, 1);
    chk("t1_madd", mst.add, 32'h100);
    chk("t1_mdata", mst.data, 32'hCAFE);
    chk("t1_mbe", mst.be, 4'hF);
    chk("t1_mwen", mst.wen, 0);
    cyc();
    mst.gnt = 1'b0; mst.r_valid = 1'b1;
    #1;
    chk("t1_strobe", sidech_vld, 1);
    chk("t1_sidech", sidech_out, 1);
    chk("t1_srvalid_off", slv.r_valid, 0);
    chk("t1_not_empty", flags.empty, 0);
    cyc();
    mst.r_valid = 1'b0;
    #1;
    chk("t1_strobe_off", sidech_vld, 0);
    chk("t1_sidech_hold", sidech_out, 1);
    chk("t1_empty", flags.empty, 1);

    // full request FIFO, order preserved on release
    for (int i = 0; i < 9; i++) begin
      slv.req = 1'b1; slv.add = 32'h200 + 32'(4 * i); slv.data = 32'h1000 + 32'(i); slv.be = 4'hF;
      sidech_in = 4'(i);
      #1;
      chk($sformatf("t2_sgnt_%0d", i), slv.gnt, (i < 8) ? 1 : 0);
      cyc();
    end
    slv.req = 1'b0;
    for (int c = 0; c < 11; c++) cyc();
    chk("t2_full", flags.full, 1);
    chk("t2_head_req", mst.req, 1);
    chk("t2_head_stable", mst.data, 32'h1000);
    for (int k = 0; k < 8; k++) begin
      mst.gnt = 1'b1; mst.r_valid = (k > 0);
      #1;
      chk($sformatf("t2_order_%0d", k), mst.data, 32'h1000 + 32'(k));
      if (k > 0) begin
        chk($sformatf("t2_sidech_%0d", k - 1), sidech_out, 64'(k - 1));
        chk($sformatf("t2_strobe_%0d", k - 1), sidech_vld, 1);
      end
      if (k == 1) chk("t2_sgnt_back", slv.gnt, 1);
      cyc();
    end
    mst.gnt = 1'b0; mst.r_valid = 1'b1;
    #1;
    chk("t2_sidech_7", sidech_out, 7);
    chk("t2_drained_req", mst.req, 0);
    cyc();
    mst.r_valid = 1'b0;
    #1;
    chk("t2_empty", flags.empty, 1);

    // outstanding limit
    fill(5, 32'h2000);
    mst.gnt = 1'b1;
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mst.req) grants++;
      cyc();
    end
    chk("t3_grants", 64'(grants), 4);
    chk("t3_req_blocked", mst.req, 0);
    mst.r_valid = 1'b1;
    #1;
    chk("t3_ack_strobe", sidech_vld, 1);
    chk("t3_ack_sidech", sidech_out, 0);
    chk("t3_no_bypass", mst.req, 0);
    cyc();
    mst.r_valid = 1'b0;
    #1;
    chk("t3_fifth_req", mst.req, 1);
    chk("t3_fifth_data", mst.data, 32'h2004);
    cyc();
    mst.gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mst.r_valid = 1'b1;
      #1;
      chk($sformatf("t3_sidech_%0d", k), sidech_out, 64'(k));
      cyc();
    end
    mst.r_valid = 1'b0;
    #1;
    chk("t3_empty", flags.empty, 1);

    // simultaneous grant and ack at two outstanding
    fill(6, 32'h3000);
    mst.gnt = 1'b1;
    cyc(); cyc();
    mst.r_valid = 1'b1;
    #1;
    chk("t4_both_strobe", sidech_vld, 1);
    chk("t4_both_sidech", sidech_out, 0);
    chk("t4_both_req", mst.req, 1);
    cyc();
    mst.r_valid = 1'b0;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (mst.req) grants++;
      cyc();
    end
    chk("t4_grants", 64'(grants), 2);
    mst.gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mst.r_valid = 1'b1;
      #1;
      chk($sformatf("t4_strobe_%0d", k), sidech_vld, 1);
      chk($sformatf("t4_sidech_%0d", k), sidech_out, 64'(k));
      cyc();
    end
    mst.r_valid = 1'b0; mst.gnt = 1'b1;
    #1;
    chk("t4_last_data", mst.data, 32'h3005);
    cyc();
    mst.gnt = 1'b0; mst.r_valid = 1'b1;
    #1;
    chk("t4_last_sidech", sidech_out, 5);
    cyc();
    mst.r_valid = 1'b0;
    #1;
    chk("t4_empty", flags.empty, 1);

    // asynchronous reset with three writes outstanding
    fill(4, 32'h4000);
    mst.gnt = 1'b1;
    cyc(); cyc(); cyc();
    mst.gnt = 1'b0;
    #1;
    chk("t5_pre_req", mst.req, 1);
    #1;
    rst = 1'b1; mst.r_valid = 1'b1;
    #1;
    chk("t5_mreq", mst.req, 0);
    chk("t5_srvalid", slv.r_valid, 0);
    chk("t5_strobe", sidech_vld, 0);
    chk("t5_sidech", sidech_out, 0);
    chk("t5_empty", flags.empty, 1);
    cyc();
    rst = 1'b0;
    #1;
    chk("t5_late_ack", sidech_vld, 0);
    cyc();
    mst.r_valid = 1'b0;
    #1;
    chk("t5_post_empty", flags.empty, 1);
    chk("t5_post_req", mst.req, 0);

    // clear with queued writes
    fill(5, 32'h5000);
    chk("t6_pre_req", mst.req, 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0; mst.gnt = 1'b1;
    #1;
    chk("t6_empty", flags.empty, 1);
    chk("t6_req", mst.req, 0);
    chk("t6_srvalid", slv.r_valid, 0);
    chk("t6_sgnt", slv.gnt, 1);
    cyc(); cyc(); cyc();
    chk("t6_req_later", mst.req, 0);
    mst.gnt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
